// File: rtl/serial_byte_receiver_if.sv
// Byte-side handshake bundle of the serial receiver: the received byte, its
// valid/ready pair and the per-frame error pulses.
interface serial_byte_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output framing_error,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/serial_byte_receiver.sv
// Asynchronous serial receiver: two-flop line synchronizer, mid-bit sampling
// FSM with LSB-first shift register, and a one-entry valid/ready holding register.
module serial_byte_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clock,
  input  logic                   reset_L,
  input  logic                   serial_in,
  serial_byte_receiver_if.master rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_p0, rx_p1;
  logic                 rx_s;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en;
  logic                 frame_done;
  logic                 frame_good;
  logic                 accept;

  // Line synchronizer: idle-high reset so a reset never looks like a start bit
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= serial_in;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (bit_cnt == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters restart on every state change and at each bit boundary
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state_nxt != state || state == IDLE || bit_cnt == BIT_LAST)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + CNT_W'(1);

      if (state_nxt != state) bit_idx <= '0;
      else if (shift_en)      bit_idx <= bit_idx + IDX_W'(1);

      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  assign frame_good = frame_done & rx_s;
  assign accept     = rx.data_valid & rx.data_ready;

  // Holding register: a new byte may replace the old one only on the accept edge
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rx.data_out      <= '0;
      rx.data_valid    <= 1'b0;
      rx.framing_error <= 1'b0;
      rx.overrun       <= 1'b0;
    end else begin
      rx.framing_error <= frame_done & ~rx_s;
      rx.overrun       <= frame_good & rx.data_valid & ~rx.data_ready;
      if (frame_good && (!rx.data_valid || rx.data_ready)) begin
        rx.data_out   <= shreg;
        rx.data_valid <= 1'b1;
      end else if (accept) begin
        rx.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Asynchronous serial-to-parallel receiver. It synchronizes a raw serial line into the clock domain, detects start bits, and samples each bit at mid-bit using a per-bit cycle counter. It shifts bits LSB-first into an internal SIPO register and presents each completed byte through a one-entry holding register with a valid/ready handshake. It sits directly downstream of the board-level serial pin and upstream of byte-consuming logic such as a command decoder or a FIFO built on the team's memory block.

## Interface
- DATA_BITS, default 8: bits per frame, received LSB first; allowed range 5–16.
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be ≥ 4. H = CLKS_PER_BIT/2, using integer division.
- clock, input, 1: single clock; all state updates on its rising edge.
- reset_L, input, 1: reset is asynchronous and active-low.
- serial_in, input, 1: raw asynchronous serial line; idle high.
- data_out, output, DATA_BITS: last accepted byte; holds its value while data_valid = 1.
- data_valid, output, 1: a byte is available in data_out.
- data_ready, input, 1: consumer accepts data_out on any rising edge where data_valid = 1.
- framing_error, output, 1: one-cycle pulse when a frame's stop bit samples as 0.
- overrun, output, 1: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- Synchronizer: two flops in series on serial_in, both reset to 1. Their output is rx_s. All FSM decisions use rx_s only.
- Counters:
  - Bit-time counter, clog2(CLKS_PER_BIT) bits wide.
  - Bit-index counter, clog2(DATA_BITS+1) bits wide.
  - Both clear on every state change.
- FSM states:
  - IDLE: when rx_s = 0, go to START.
  - START: count H cycles. At count H−1, if rx_s = 0, go to DATA. If rx_s = 1, treat it as a false start and go to IDLE with no outputs.
  - DATA: at count CLKS_PER_BIT−1, sample rx_s and shift it in at the MSB with a right shift. After DATA_BITS samples, go to STOP.
  - STOP: at count CLKS_PER_BIT−1, sample rx_s and then always go to IDLE.
    - If rx_s = 1, the frame is good: deliver the byte to the holding register.
    - If rx_s = 0, pulse framing_error for one cycle and discard the byte.
- Holding register and handshake:
  - Accept: the edge where data_valid = 1 and data_ready = 1. After an accept, data_valid clears unless a new good frame completes on that same edge.
  - Good frame with data_valid = 0: load data_out and set data_valid.
  - Good frame on the same edge as an accept: load the new byte. data_valid stays 1. No overrun.
  - Good frame with data_valid = 1 and no accept: drop the new byte. data_out is unchanged. Pulse overrun for one cycle.
- Framing error and overrun cannot occur on the same frame.
- data_ready is ignored while data_valid = 0.

## Timing
- Reset values:
  - data_out = 0, data_valid = 0, framing_error = 0, overrun = 0.
  - FSM in IDLE, shift register = 0, counters = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame: the frame is abandoned and all state returns to reset values immediately, without waiting for a clock edge.
  - After reset_L deasserts, the receiver waits in IDLE for a fresh falling edge.
  - A line still low at deassert starts a frame from rx_s.
- Define t0 as the first rising edge where the first synchronizer flop captures 0.
  - rx_s = 0 after edge t0+1; FSM enters START at t0+2.
  - Start bit sampled at t0+2+H.
  - Data bit i (0-based) sampled at t0+2+H+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at t0+2+H+(DATA_BITS+1)·CLKS_PER_BIT. data_valid, framing_error and overrun update on that same edge.
  - With defaults: byte available after edge t0+154.
- FSM re-enters IDLE on the stop-sample edge, i.e. mid stop bit. A start bit immediately following the stop bit is detected normally, so back-to-back frames are supported.
- Glitches are rejected when the low pulse is shorter than about H−2 cycles, as rx_s is high again at the start sample.
- Outputs are registered; there is no combinational path from serial_in or data_ready to any output.

## Test plan
- Defaults, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit), data_ready = 0 → data_valid rises at t0+154 with data_out = 0xA5. Raise data_ready for one edge → data_valid = 0 next cycle.
- Back-to-back frames 0x00 then 0xFF, no idle gap, data_ready held at 1 → two valid bytes 0x00 and 0xFF in order; no overrun, no framing_error.
- 3-cycle low glitch on an idle line → FSM returns to IDLE; no data_valid, no error pulses.
- Frame 0x3C with stop bit driven 0 → one-cycle framing_error at the stop-sample edge; data_valid stays 0 and data_out is unchanged.
- Two good frames 0x11 then 0x22 with data_ready = 0 → data_out = 0x11, one-cycle overrun at the second stop-sample edge. Repeat with data_ready pulsed on exactly that edge → data_out = 0x22, data_valid stays 1, no overrun.
- Assert reset_L low for 2 cycles during data bit 3, then send 0x5A → all outputs return to 0 immediately; the next frame is received correctly as 0x5A.
